imem_boot_loader: RTL and testbench



---
 rtl/boot_pkg.sv | 17 +
 rtl/word_assembler.sv | 32 +++
 rtl/imem_boot_loader.sv | 151 +++++++++++++++
 tb/tb_imem_boot_loader.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/boot_pkg.sv
// Shared types and constants for the instruction-memory boot loader.
// Optional feature macro: BOOT_CHECKSUM_EN (trailing XOR checksum byte).
package boot_pkg;

    typedef enum logic [2:0] {
        ST_HDR0 = 3'd0,
        ST_HDR1 = 3'd1,
        ST_DATA = 3'd2,
        ST_CHK  = 3'd3,
        ST_DONE = 3'd4,
        ST_ERR  = 3'd5
    } boot_state_e;

    localparam int BOOT_LEN_W = 16;
    localparam int BYTE_CNT_W = 2;

endpackage

// File: rtl/word_assembler.sv
// Packs four bytes into a little-endian 32-bit word; word_vld pulses combinationally
// with the 4th byte so the caller registers the write one cycle after acceptance.
module word_assembler
    import boot_pkg::*;
(
    input  logic        Clk,
    input  logic        Rst,
    input  logic        i_clr,
    input  logic        i_byte_vld,
    input  logic [7:0]  i_byte_dat,
    output logic [31:0] o_word_dat,
    output logic        o_word_vld
);

    logic [BYTE_CNT_W-1:0] r_cnt;
    logic [23:0]           r_shift;

    // Only the first three bytes need storage; the 4th is taken straight from the input.
    assign o_word_vld = i_byte_vld && (r_cnt == '1);
    assign o_word_dat = {i_byte_dat, r_shift};

    always_ff @(posedge Clk) begin
        if (Rst || i_clr) begin
            r_cnt   <= '0;
            r_shift <= '0;
        end else if (i_byte_vld) begin
            r_cnt   <= r_cnt + 1'b1;
            r_shift <= {i_byte_dat, r_shift[23:8]};
        end
    end

endmodule

// File: rtl/imem_boot_loader.sv
// Byte-stream loader writing instruction words from address 0 and holding the core in reset
// until the image is complete. Optional macro BOOT_CHECKSUM_EN adds a trailing XOR check byte.
module imem_boot_loader
    import boot_pkg::*;
#(
    parameter int ADDR_W = 8
) (
    input  logic              Clk,
    input  logic              Rst,
    input  logic              Rx_valid,
    input  logic [7:0]        Rx_data,
    output logic              Rx_ready,
    input  logic              Restart,
    output logic              Imem_wr_en,
    output logic [ADDR_W-1:0] Imem_wr_addr,
    output logic [31:0]       Imem_wr_data,
    output logic              Core_rst_n,
    output logic              Done,
    output logic              Err
);

    localparam int MAX_WORDS = 2**ADDR_W;

    boot_state_e           r_state;
    boot_state_e           w_state_nxt;
    logic [BOOT_LEN_W-1:0] r_len;
    logic [BOOT_LEN_W-1:0] w_len_full;
    logic [ADDR_W:0]       r_word_cnt;
    logic                  w_accept;
    logic                  w_clr;
    logic                  w_len_ok;
    logic                  w_last;
    logic                  w_word_vld;
    logic [31:0]           w_word_dat;
    logic                  r_wr_en;
    logic [ADDR_W-1:0]     r_wr_addr;
    logic [31:0]           r_wr_data;
    logic                  r_done;
    logic                  r_err;
    logic                  r_core_rst_n;

    assign Rx_ready   = (r_state == ST_HDR0) || (r_state == ST_HDR1) ||
                        (r_state == ST_DATA) || (r_state == ST_CHK);
    assign w_accept   = Rx_valid && Rx_ready;
    assign w_len_full = {Rx_data, r_len[7:0]};
    assign w_len_ok   = (w_len_full != '0) && (int'(w_len_full) <= MAX_WORDS);
    // Counter is one bit wider than the address so LEN = MAX_WORDS compares cleanly.
    assign w_last     = (BOOT_LEN_W'(r_word_cnt) == (r_len - 1'b1));

    word_assembler u_word_assembler (
        .Clk        (Clk),
        .Rst        (Rst),
        .i_clr      (w_clr),
        .i_byte_vld (w_accept && (r_state == ST_DATA)),
        .i_byte_dat (Rx_data),
        .o_word_dat (w_word_dat),
        .o_word_vld (w_word_vld)
    );

`ifdef BOOT_CHECKSUM_EN
    logic [7:0] r_xor;

    always_ff @(posedge Clk) begin
        if (Rst || w_clr) begin
            r_xor <= '0;
        end else if (w_accept && (r_state == ST_DATA)) begin
            r_xor <= r_xor ^ Rx_data;
        end
    end
`endif

    always_ff @(posedge Clk) begin
        if (Rst) begin
            r_state <= ST_HDR0;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_clr       = 1'b0;
        case (r_state)
            ST_HDR0: if (w_accept) w_state_nxt = ST_HDR1;
            ST_HDR1: if (w_accept) w_state_nxt = w_len_ok ? ST_DATA : ST_ERR;
            ST_DATA: begin
                if (w_word_vld && w_last) begin
`ifdef BOOT_CHECKSUM_EN
                    w_state_nxt = ST_CHK;
`else
                    w_state_nxt = ST_DONE;
`endif
                end
            end
`ifdef BOOT_CHECKSUM_EN
            ST_CHK: if (w_accept) w_state_nxt = (Rx_data == r_xor) ? ST_DONE : ST_ERR;
`endif
            ST_DONE, ST_ERR: begin
                if (Restart) begin
                    w_state_nxt = ST_HDR0;
                    w_clr       = 1'b1;
                end
            end
            default: w_state_nxt = ST_HDR0;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            r_len      <= '0;
            r_word_cnt <= '0;
        end else begin
            if (w_accept && (r_state == ST_HDR0)) r_len[7:0]  <= Rx_data;
            if (w_accept && (r_state == ST_HDR1)) r_len[15:8] <= Rx_data;
            if (w_clr) begin
                r_word_cnt <= '0;
            end else if (w_word_vld) begin
                r_word_cnt <= r_word_cnt + 1'b1;
            end
        end
    end

    // Status outputs track the state being entered so they change with the state register.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            r_wr_en      <= 1'b0;
            r_wr_addr    <= '0;
            r_wr_data    <= '0;
            r_done       <= 1'b0;
            r_err        <= 1'b0;
            r_core_rst_n <= 1'b0;
        end else begin
            r_wr_en <= w_word_vld;
            if (w_word_vld) begin
                r_wr_addr <= r_word_cnt[ADDR_W-1:0];
                r_wr_data <= w_word_dat;
            end
            r_done       <= (w_state_nxt == ST_DONE);
            r_err        <= (w_state_nxt == ST_ERR);
            r_core_rst_n <= (w_state_nxt == ST_DONE);
        end
    end

    assign Imem_wr_en   = r_wr_en;
    assign Imem_wr_addr = r_wr_addr;
    assign Imem_wr_data = r_wr_data;
    assign Done         = r_done;
    assign Err          = r_err;
    assign Core_rst_n   = r_core_rst_n;

endmodule

// File: tb/tb_imem_boot_loader.sv
// Directed bench for imem_boot_loader; builds with or without BOOT_CHECKSUM_EN.
module tb_imem_boot_loader;

    localparam int ADDR_W = 8;

    logic              Clk = 1'b0;
    logic              Rst = 1'b1;
    logic              Rx_valid = 1'b0;
    logic [7:0]        Rx_data = 8'h00;
    logic              Rx_ready;
    logic              Restart = 1'b0;
    logic              Imem_wr_en;
    logic [ADDR_W-1:0] Imem_wr_addr;
    logic [31:0]       Imem_wr_data;
    logic              Core_rst_n;
    logic              Done;
    logic              Err;

    int         n_checks = 0;
    int         n_errors = 0;
    logic [7:0] tb_xor   = 8'h00;

    logic [ADDR_W-1:0] wr_addr_q[$];
    logic [31:0]       wr_data_q[$];

    imem_boot_loader #(.ADDR_W(ADDR_W)) dut (
        .Clk          (Clk),
        .Rst          (Rst),
        .Rx_valid     (Rx_valid),
        .Rx_data      (Rx_data),
        .Rx_ready     (Rx_ready),
        .Restart      (Restart),
        .Imem_wr_en   (Imem_wr_en),
        .Imem_wr_addr (Imem_wr_addr),
        .Imem_wr_data (Imem_wr_data),
        .Core_rst_n   (Core_rst_n),
        .Done         (Done),
        .Err          (Err)
    );

    always #5 Clk = ~Clk;

    always @(negedge Clk) begin
        if (Imem_wr_en === 1'b1) begin
            wr_addr_q.push_back(Imem_wr_addr);
            wr_data_q.push_back(Imem_wr_data);
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
        $fatal(1);
    end

    task automatic idle(input int n);
        repeat (n) @(posedge Clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        Rx_valid = 1'b1;
        Rx_data  = b;
        @(posedge Clk);
        #1;
        Rx_valid = 1'b0;
    endtask

    task automatic send_hdr(input logic [15:0] len);
        tb_xor = 8'h00;
        send_byte(len[7:0]);
        send_byte(len[15:8]);
    endtask

    task automatic send_word(input logic [31:0] w, input bit gaps);
        for (int k = 0; k < 4; k++) begin
            if (gaps) idle($urandom_range(0, 3));
            send_byte(w[8*k +: 8]);
            tb_xor = tb_xor ^ w[8*k +: 8];
        end
    endtask

    task automatic send_chk(input logic [7:0] flip);
`ifdef BOOT_CHECKSUM_EN
        send_byte(tb_xor ^ flip);
`else
        flip = flip;
`endif
    endtask

    task automatic apply_reset();
        Rst = 1'b1;
        idle(1);
        Rst = 1'b0;
        wr_addr_q.delete();
        wr_data_q.delete();
    endtask

    task automatic test_reset();
        Rst = 1'b1;
        idle(2);
        n_checks++; if (Rx_ready !== 1'b1) begin n_errors++; $display("FAIL reset_rx_ready got %b want 1", Rx_ready); end
        n_checks++; if (Imem_wr_en !== 1'b0) begin n_errors++; $display("FAIL reset_wr_en got %b want 0", Imem_wr_en); end
        n_checks++; if (Imem_wr_addr !== 8'h00) begin n_errors++; $display("FAIL reset_wr_addr got %h want 00", Imem_wr_addr); end
        n_checks++; if (Imem_wr_data !== 32'h0) begin n_errors++; $display("FAIL reset_wr_data got %h want 0", Imem_wr_data); end
        n_checks++; if (Core_rst_n !== 1'b0) begin n_errors++; $display("FAIL reset_core_rst_n got %b want 0", Core_rst_n); end
        n_checks++; if (Done !== 1'b0) begin n_errors++; $display("FAIL reset_done got %b want 0", Done); end
        n_checks++; if (Err !== 1'b0) begin n_errors++; $display("FAIL reset_err got %b want 0", Err); end
        Rst = 1'b0;
    endtask

    task automatic test_single_word();
        apply_reset();
        send_hdr(16'd1);
        send_word(32'h0000_0013, 1'b0);
        n_checks++; if (Imem_wr_en !== 1'b1) begin n_errors++; $display("FAIL single_wr_en got %b want 1", Imem_wr_en); end
        n_checks++; if (Imem_wr_addr !== 8'h00) begin n_errors++; $display("FAIL single_wr_addr got %h want 00", Imem_wr_addr); end
        n_checks++; if (Imem_wr_data !== 32'h0000_0013) begin n_errors++; $display("FAIL single_wr_data got %h want 00000013", Imem_wr_data); end
`ifdef BOOT_CHECKSUM_EN
        n_checks++; if (Done !== 1'b0) begin n_errors++; $display("FAIL single_done_before_chk got %b want 0", Done); end
        send_chk(8'h00);
`endif
        n_checks++; if (Done !== 1'b1) begin n_errors++; $display("FAIL single_done got %b want 1", Done); end
        n_checks++; if (Core_rst_n !== 1'b1) begin n_errors++; $display("FAIL single_core_rst_n got %b want 1", Core_rst_n); end
        n_checks++; if (Rx_ready !== 1'b0) begin n_errors++; $display("FAIL single_rx_ready got %b want 0", Rx_ready); end
        idle(2);
        n_checks++; if (wr_addr_q.size() != 1) begin n_errors++; $display("FAIL single_write_count got %0d want 1", wr_addr_q.size()); end
        n_checks++; if (Err !== 1'b0) begin n_errors++; $display("FAIL single_err got %b want 0", Err); end
    endtask

    task automatic test_gaps();
        logic [31:0] img[3];
        img[0] = 32'h1122_3344;
        img[1] = 32'hA5A5_F00F;
        img[2] = 32'hDEAD_BEEF;
        apply_reset();
        send_hdr(16'd3);
        for (int i = 0; i < 3; i++) send_word(img[i], 1'b1);
        idle($urandom_range(0, 3));
        send_chk(8'h00);
        idle(3);
        n_checks++; if (wr_addr_q.size() != 3) begin n_errors++; $display("FAIL gaps_write_count got %0d want 3", wr_addr_q.size()); end
        for (int i = 0; i < 3 && i < wr_addr_q.size(); i++) begin
            n_checks++; if (wr_addr_q[i] !== 8'(i)) begin n_errors++; $display("FAIL gaps_addr[%0d] got %h want %h", i, wr_addr_q[i], 8'(i)); end
            n_checks++; if (wr_data_q[i] !== img[i]) begin n_errors++; $display("FAIL gaps_data[%0d] got %h want %h", i, wr_data_q[i], img[i]); end
        end
        n_checks++; if (Done !== 1'b1) begin n_errors++; $display("FAIL gaps_done got %b want 1", Done); end
    endtask

    task automatic test_bad_len();
        logic [15:0] lens[2];
        lens[0] = 16'd0;
        lens[1] = 16'd257;
        for (int i = 0; i < 2; i++) begin
            apply_reset();
            send_hdr(lens[i]);
            n_checks++; if (Err !== 1'b1) begin n_errors++; $display("FAIL badlen%0d_err got %b want 1", lens[i], Err); end
            n_checks++; if (Rx_ready !== 1'b0) begin n_errors++; $display("FAIL badlen%0d_rx_ready got %b want 0", lens[i], Rx_ready); end
            n_checks++; if (Core_rst_n !== 1'b0) begin n_errors++; $display("FAIL badlen%0d_core_rst_n got %b want 0", lens[i], Core_rst_n); end
            send_word(32'h0403_0201, 1'b0);
            idle(2);
            n_checks++; if (wr_addr_q.size() != 0) begin n_errors++; $display("FAIL badlen%0d_writes got %0d want 0", lens[i], wr_addr_q.size()); end
            n_checks++; if (Err !== 1'b1) begin n_errors++; $display("FAIL badlen%0d_err_hold got %b want 1", lens[i], Err); end
        end
    endtask

    task automatic test_max_len();
        logic [7:0] b;
        apply_reset();
        send_hdr(16'd256);
        n_checks++; if (Err !== 1'b0 || Rx_ready !== 1'b1) begin n_errors++; $display("FAIL maxlen_hdr got err=%b rdy=%b want err=0 rdy=1", Err, Rx_ready); end
        for (int i = 0; i < 256; i++) begin
            b = 8'(i);
            send_word({b, 8'h5A, ~b, b + 8'h01}, 1'b0);
        end
        send_chk(8'h00);
        idle(2);
        n_checks++; if (wr_addr_q.size() != 256) begin n_errors++; $display("FAIL maxlen_write_count got %0d want 256", wr_addr_q.size()); end
        for (int i = 0; i < 256 && i < wr_addr_q.size(); i++) begin
            b = 8'(i);
            n_checks++; if (wr_addr_q[i] !== b || wr_data_q[i] !== {b, 8'h5A, ~b, b + 8'h01}) begin
                n_errors++; $display("FAIL maxlen_word[%0d] got %h:%h want %h:%h", i, wr_addr_q[i], wr_data_q[i], b, {b, 8'h5A, ~b, b + 8'h01});
            end
        end
        n_checks++; if (Done !== 1'b1 || Err !== 1'b0) begin n_errors++; $display("FAIL maxlen_status got done=%b err=%b want done=1 err=0", Done, Err); end
    endtask

`ifdef BOOT_CHECKSUM_EN
    task automatic test_checksum_err();
        apply_reset();
        send_hdr(16'd2);
        send_word(32'h0102_0304, 1'b0);
        send_word(32'hF0E0_D0C0, 1'b0);
        send_chk(8'h01);
        n_checks++; if (Err !== 1'b1) begin n_errors++; $display("FAIL chk_err got %b want 1", Err); end
        n_checks++; if (Core_rst_n !== 1'b0 || Done !== 1'b0) begin n_errors++; $display("FAIL chk_core got rst_n=%b done=%b want 0 0", Core_rst_n, Done); end
        idle(2);
        n_checks++; if (wr_addr_q.size() != 2) begin n_errors++; $display("FAIL chk_write_count got %0d want 2", wr_addr_q.size()); end
        n_checks++; if (Core_rst_n !== 1'b0) begin n_errors++; $display("FAIL chk_core_hold got %b want 0", Core_rst_n); end
    endtask
`endif

    task automatic test_reset_mid();
        apply_reset();
        send_hdr(16'd2);
        send_word(32'h0BAD_F00D, 1'b0);
        send_byte(8'h77);
        send_byte(8'h66);
        Rst = 1'b1;
        idle(1);
        n_checks++; if (Imem_wr_en !== 1'b0 || Imem_wr_addr !== 8'h00 || Imem_wr_data !== 32'h0) begin
            n_errors++; $display("FAIL rstmid_wr got en=%b addr=%h data=%h want 0 00 0", Imem_wr_en, Imem_wr_addr, Imem_wr_data);
        end
        n_checks++; if (Done !== 1'b0 || Err !== 1'b0 || Core_rst_n !== 1'b0 || Rx_ready !== 1'b1) begin
            n_errors++; $display("FAIL rstmid_status got done=%b err=%b rst_n=%b rdy=%b want 0 0 0 1", Done, Err, Core_rst_n, Rx_ready);
        end
        Rst = 1'b0;
        idle(2);
        n_checks++; if (wr_addr_q.size() != 1) begin n_errors++; $display("FAIL rstmid_partial_writes got %0d want 1", wr_addr_q.size()); end
        wr_addr_q.delete();
        wr_data_q.delete();
        send_hdr(16'd1);
        send_word(32'hCAFE_F00D, 1'b0);
        send_chk(8'h00);
        idle(2);
        n_checks++; if (wr_addr_q.size() != 1) begin n_errors++; $display("FAIL rstmid_reload_count got %0d want 1", wr_addr_q.size()); end
        else if (wr_addr_q[0] !== 8'h00 || wr_data_q[0] !== 32'hCAFE_F00D) begin
            n_errors++; $display("FAIL rstmid_reload got %h:%h want 00:cafef00d", wr_addr_q[0], wr_data_q[0]);
        end
        n_checks++; if (Done !== 1'b1) begin n_errors++; $display("FAIL rstmid_done got %b want 1", Done); end
    endtask

    task automatic test_restart();
        Restart = 1'b1;
        idle(1);
        Restart = 1'b0;
        n_checks++; if (Core_rst_n !== 1'b0 || Done !== 1'b0) begin n_errors++; $display("FAIL restart_fall got rst_n=%b done=%b want 0 0", Core_rst_n, Done); end
        n_checks++; if (Rx_ready !== 1'b1) begin n_errors++; $display("FAIL restart_rx_ready got %b want 1", Rx_ready); end
        wr_addr_q.delete();
        wr_data_q.delete();
        send_hdr(16'd2);
        Restart = 1'b1;
        send_word(32'h8765_4321, 1'b0);
        Restart = 1'b0;
        send_word(32'h0FED_CBA9, 1'b0);
        send_chk(8'h00);
        idle(2);
        n_checks++; if (wr_addr_q.size() != 2) begin n_errors++; $display("FAIL restart_write_count got %0d want 2", wr_addr_q.size()); end
        else begin
            n_checks++; if (wr_addr_q[0] !== 8'h00 || wr_data_q[0] !== 32'h8765_4321) begin
                n_errors++; $display("FAIL restart_word0 got %h:%h want 00:87654321", wr_addr_q[0], wr_data_q[0]);
            end
            n_checks++; if (wr_addr_q[1] !== 8'h01 || wr_data_q[1] !== 32'h0FED_CBA9) begin
                n_errors++; $display("FAIL restart_word1 got %h:%h want 01:0fedcba9", wr_addr_q[1], wr_data_q[1]);
            end
        end
        n_checks++; if (Done !== 1'b1 || Core_rst_n !== 1'b1) begin n_errors++; $display("FAIL restart_done got done=%b rst_n=%b want 1 1", Done, Core_rst_n); end
    endtask

    initial begin
        test_reset();
        test_single_word();
        test_gaps();
        test_bad_len();
        test_max_len();
`ifdef BOOT_CHECKSUM_EN
        test_checksum_err();
`endif
        test_reset_mid();
        test_restart();
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
